// File: rtl/layer_compositor_if.sv
// Pixel bus between the sprite/font/background fetch logic and the layer compositor.
// The master modport is the upstream side; the compositor uses the slave modport.
interface layer_compositor_if #(
    parameter int NUM_LAYERS = 6,
    parameter int COLOR_W    = 8
);
    logic                                    frame_start;
    logic [1:0]                              stage_req;
    logic [NUM_LAYERS-1:0]                   layer_on;
    logic [NUM_LAYERS-1:0][3*COLOR_W-1:0]    layer_pixel;
    logic                                    text_on;
    logic [3*COLOR_W-1:0]                    bg_pixel;
    logic [COLOR_W-1:0]                      VGA_R;
    logic [COLOR_W-1:0]                      VGA_G;
    logic [COLOR_W-1:0]                      VGA_B;
    logic [1:0]                              active_stage;
    logic                                    fade_busy;

    modport master (
        output frame_start, stage_req, layer_on, layer_pixel, text_on, bg_pixel,
        input  VGA_R, VGA_G, VGA_B, active_stage, fade_busy
    );
    modport slave (
        input  frame_start, stage_req, layer_on, layer_pixel, text_on, bg_pixel,
        output VGA_R, VGA_G, VGA_B, active_stage, fade_busy
    );
endinterface

// File: rtl/layer_compositor.sv
// Two-stage layer compositor with stage-screen selection and frame-synchronous fade.
// Optional build macro TRANSPARENT_KEY_EN: magenta layer pixels are treated as not hit.
module chan_scale #(
    parameter int COLOR_W = 8,
    parameter int LEVEL_W = 4
) (
    input  logic [COLOR_W-1:0] c,
    input  logic [LEVEL_W:0]   level,
    output logic [COLOR_W-1:0] y
);
    logic [COLOR_W+LEVEL_W:0] prod;
    assign prod = {{(LEVEL_W+1){1'b0}}, c} * {{COLOR_W{1'b0}}, level};
    assign y    = prod[LEVEL_W +: COLOR_W];
endmodule

module layer_compositor #(
    parameter int NUM_LAYERS      = 6,
    parameter int COLOR_W         = 8,
    parameter int LEVEL_W         = 4,
    parameter int FRAMES_PER_STEP = 2
) (
    input  logic Clk,
    input  logic Reset,
    layer_compositor_if.slave bus
);
    localparam int PIX_W = 3 * COLOR_W;
    localparam logic [LEVEL_W:0] LVL_MAX = {1'b1, {LEVEL_W{1'b0}}};

    // 8-bit constants are left-aligned into COLOR_W-bit channels.
    function automatic logic [PIX_W-1:0] fixed_color(input logic [23:0] rgb);
        logic [COLOR_W+7:0] t;
        logic [PIX_W-1:0]   p;
        p = '0;
        for (int c = 0; c < 3; c++) begin
            t = {rgb[c*8 +: 8], {COLOR_W{1'b0}}};
            p[c*COLOR_W +: COLOR_W] = t[COLOR_W+7 -: COLOR_W];
        end
        return p;
    endfunction

    localparam logic [PIX_W-1:0] COL_START = fixed_color(24'hFF0000);
    localparam logic [PIX_W-1:0] COL_WIN   = fixed_color(24'h9C1D08);
    localparam logic [PIX_W-1:0] COL_LOSE  = fixed_color(24'h57007F);
    localparam logic [PIX_W-1:0] COL_TEXT  = fixed_color(24'h6C6C6C);
`ifdef TRANSPARENT_KEY_EN
    localparam logic [PIX_W-1:0] COL_KEY   = fixed_color(24'hFF00FF);
`endif

    typedef enum logic [1:0] {SHOW, FADE_OUT, FADE_IN} state_t;

    state_t          state;
    logic [LEVEL_W:0] level;
    logic [7:0]      fcnt;
    logic [1:0]      stage_q;
    logic            busy_q;
    logic            step;

    logic [NUM_LAYERS-1:0]         hit;
    logic [2:0][COLOR_W-1:0]       layer_sel, sel, sel_q, scaled, rgb_q;

    // Stage 1: priority pick, lowest layer index wins.
    always_comb begin
        for (int i = 0; i < NUM_LAYERS; i++) begin
`ifdef TRANSPARENT_KEY_EN
            hit[i] = bus.layer_on[i] && (bus.layer_pixel[i] != COL_KEY);
`else
            hit[i] = bus.layer_on[i];
`endif
        end
        layer_sel = bus.bg_pixel;
        for (int i = NUM_LAYERS-1; i >= 0; i--)
            if (hit[i]) layer_sel = bus.layer_pixel[i];
        case (stage_q)
            2'd0:    sel = bus.text_on ? COL_START : '0;
            2'd2:    sel = bus.text_on ? '0 : COL_WIN;
            2'd3:    sel = bus.text_on ? '0 : COL_LOSE;
            default: sel = (|hit) ? layer_sel : (bus.text_on ? COL_TEXT : bus.bg_pixel);
        endcase
    end

    // Stage 2: per-channel brightness scaling.
    for (genvar c = 0; c < 3; c++) begin : g_scale
        chan_scale #(.COLOR_W(COLOR_W), .LEVEL_W(LEVEL_W)) u_scale (
            .c(sel_q[c]), .level(level), .y(scaled[c])
        );
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sel_q <= '0;
            rgb_q <= '0;
        end else begin
            sel_q <= sel;
            rgb_q <= scaled;
        end
    end

    assign step = bus.frame_start && (fcnt == 8'(FRAMES_PER_STEP-1));

    // Level and active stage only move on frame_start, so frames are never split.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= SHOW;
            level   <= LVL_MAX;
            fcnt    <= '0;
            stage_q <= 2'd0;
            busy_q  <= 1'b0;
        end else begin
            case (state)
                SHOW: begin
                    if (bus.stage_req != stage_q) begin
                        state  <= FADE_OUT;
                        fcnt   <= '0;
                        busy_q <= 1'b1;
                    end
                end
                FADE_OUT: begin
                    if (step) begin
                        fcnt <= '0;
                        if (level == '0) begin
                            stage_q <= bus.stage_req;
                            state   <= FADE_IN;
                        end else begin
                            level <= level - 1'b1;
                        end
                    end else if (bus.frame_start) begin
                        fcnt <= fcnt + 8'd1;
                    end
                end
                FADE_IN: begin
                    if (bus.stage_req != stage_q) begin
                        state <= FADE_OUT;
                        fcnt  <= '0;
                    end else if (step) begin
                        fcnt  <= '0;
                        level <= level + 1'b1;
                        if (level == LVL_MAX - 1'b1) begin
                            state  <= SHOW;
                            busy_q <= 1'b0;
                        end
                    end else if (bus.frame_start) begin
                        fcnt <= fcnt + 8'd1;
                    end
                end
                default: begin
                    state  <= SHOW;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.VGA_R        = rgb_q[2];
    assign bus.VGA_G        = rgb_q[1];
    assign bus.VGA_B        = rgb_q[0];
    assign bus.active_stage = stage_q;
    assign bus.fade_busy    = busy_q;
endmodule

// File: tb/tb_layer_compositor.sv
// Directed bench for layer_compositor: vector table in battle stage plus fade sequences.
module tb_layer_compositor;
    logic Clk = 1'b0;
    logic Reset = 1'b1;
    int total = 0;
    int bad = 0;

    layer_compositor_if #(.NUM_LAYERS(6), .COLOR_W(8)) bus ();

    layer_compositor #(.NUM_LAYERS(6), .COLOR_W(8), .LEVEL_W(4), .FRAMES_PER_STEP(2)) dut (
        .Clk(Clk), .Reset(Reset), .bus(bus)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [5:0]       on;
        logic             text;
        logic [23:0]      bg;
        logic [5:0][23:0] lp;
        logic [23:0]      exp;
    } vec_t;

    vec_t vec [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rgb();
        return {8'h0, bus.VGA_R, bus.VGA_G, bus.VGA_B};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            bus.frame_start = 1'b1;
            @(negedge Clk);
            bus.frame_start = 1'b0;
            @(negedge Clk);
        end
    endtask

    task automatic set_pix(input logic [5:0] on, input logic text, input logic [23:0] bg);
        bus.layer_on = on;
        bus.text_on  = text;
        bus.bg_pixel = bg;
    endtask

    initial begin
        vec[0] = '{6'b000000, 1'b0, 24'h123456, '{default: 24'h0}, 24'h123456};
        vec[1] = '{6'b000000, 1'b0, 24'hABCDEF, '{default: 24'h0}, 24'hABCDEF};
        vec[2] = '{6'b000110, 1'b0, 24'h111111,
                   {24'h0, 24'h0, 24'h0, 24'h0000FF, 24'h00FF00, 24'h0}, 24'h00FF00};
        vec[3] = '{6'b000000, 1'b1, 24'h111111, '{default: 24'h0}, 24'h6C6C6C};
        vec[4] = '{6'b100000, 1'b1, 24'h222222,
                   {24'h314159, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0}, 24'h314159};
        vec[5] = '{6'b111111, 1'b0, 24'h333333,
                   {24'h060606, 24'h050505, 24'h040404, 24'h030303, 24'h020202, 24'h010203},
                   24'h010203};
`ifdef TRANSPARENT_KEY_EN
        vec[6] = '{6'b000011, 1'b0, 24'h444444,
                   {24'h0, 24'h0, 24'h0, 24'h0, 24'hAABBCC, 24'hFF00FF}, 24'hAABBCC};
`else
        vec[6] = '{6'b000011, 1'b0, 24'h444444,
                   {24'h0, 24'h0, 24'h0, 24'h0, 24'hAABBCC, 24'hFF00FF}, 24'hFF00FF};
`endif
        vec[7] = '{6'b000000, 1'b1, 24'h777777, '{default: 24'h0}, 24'h6C6C6C};

        bus.frame_start = 1'b0;
        bus.stage_req   = 2'd0;
        bus.layer_pixel = '0;
        set_pix(6'b0, 1'b0, 24'h123456);

        // Reset values
        cyc(2);
        chk("reset_rgb", rgb(), 32'h0);
        chk("reset_stage", {30'h0, bus.active_stage}, 32'd0);
        chk("reset_busy", {31'h0, bus.fade_busy}, 32'd0);

        // Fade from start to battle
        Reset = 1'b0;
        bus.stage_req = 2'd1;
        cyc(1);
        chk("busy_rise_1", {31'h0, bus.fade_busy}, 32'd1);
        frames(33);
        chk("stage_before_swap", {30'h0, bus.active_stage}, 32'd0);
        frames(1);
        chk("stage_swap_1", {30'h0, bus.active_stage}, 32'd1);
        frames(16);
        chk("half_level_bg", rgb(), 32'h00091A2B);
        frames(15);
        chk("busy_late_fadein", {31'h0, bus.fade_busy}, 32'd1);
        frames(1);
        chk("busy_fall_1", {31'h0, bus.fade_busy}, 32'd0);
        cyc(2);
        chk("battle_bg_full", rgb(), 32'h00123456);

        // Battle vectors with 2-cycle latency
        for (int i = 0; i < 8; i++) begin
            bus.layer_pixel = vec[i].lp;
            set_pix(vec[i].on, vec[i].text, vec[i].bg);
            cyc(1);
            if (i > 0) chk($sformatf("latency_hold_%0d", i), rgb(), {8'h0, vec[i-1].exp});
            cyc(1);
            chk($sformatf("vec_%0d", i), rgb(), {8'h0, vec[i].exp});
        end

        // Battle -> win, interrupted by lose at level 8
        bus.layer_pixel = '0;
        set_pix(6'b0, 1'b0, 24'h123456);
        bus.stage_req = 2'd2;
        cyc(1);
        chk("busy_rise_2", {31'h0, bus.fade_busy}, 32'd1);
        frames(16);
        chk("fadeout_half", rgb(), 32'h00091A2B);
        frames(16);
        chk("fadeout_black", rgb(), 32'h0);
        frames(1);
        chk("stage_hold_33", {30'h0, bus.active_stage}, 32'd1);
        frames(1);
        chk("stage_swap_2", {30'h0, bus.active_stage}, 32'd2);
        frames(16);
        chk("win_level8", rgb(), 32'h004E0E04);
        bus.stage_req = 2'd3;
        cyc(3);
        chk("no_jump", rgb(), 32'h004E0E04);
        chk("busy_redirect", {31'h0, bus.fade_busy}, 32'd1);
        frames(2);
        chk("win_level7", rgb(), 32'h00440C03);
        frames(15);
        chk("stage_hold_lose", {30'h0, bus.active_stage}, 32'd2);
        frames(1);
        chk("stage_swap_3", {30'h0, bus.active_stage}, 32'd3);
        frames(32);
        chk("busy_fall_3", {31'h0, bus.fade_busy}, 32'd0);
        cyc(2);
        chk("lose_bg", rgb(), 32'h0057007F);

        // Reset mid FADE_OUT
        bus.stage_req = 2'd0;
        frames(4);
        Reset = 1'b1;
        cyc(1);
        chk("midreset_rgb", rgb(), 32'h0);
        chk("midreset_stage", {30'h0, bus.active_stage}, 32'd0);
        chk("midreset_busy", {31'h0, bus.fade_busy}, 32'd0);
        Reset = 1'b0;
        bus.text_on = 1'b1;
        cyc(2);
        chk("start_text_full", rgb(), 32'h00FF0000);
        chk("resume_busy", {31'h0, bus.fade_busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
